// File: rtl/plic_target_if.sv
// Claim/complete and arbitration bundle between a PLIC target controller and
// its gateways/register wrapper. The slave side is the target controller.
interface plic_target_if #(
    parameter int SRC_NUM    = 31,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = $clog2(SRC_NUM + 1)
);
    logic [SRC_NUM-1:0]            ip_i;
    logic [SRC_NUM-1:0]            ie_i;
    logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i;
    logic [PRIO_WIDTH-1:0]         thold_i;
    logic                          claim_req_i;
    logic                          claim_vld_o;
    logic [ID_WIDTH-1:0]           claim_id_o;
    logic                          comp_req_i;
    logic [ID_WIDTH-1:0]           comp_id_i;
    logic [SRC_NUM-1:0]            clam_o;
    logic [SRC_NUM-1:0]            comp_o;
    logic                          irq_o;

    modport slave (
        input  ip_i, ie_i, prio_i, thold_i, claim_req_i, comp_req_i, comp_id_i,
        output claim_vld_o, claim_id_o, clam_o, comp_o, irq_o
    );

    modport master (
        output ip_i, ie_i, prio_i, thold_i, claim_req_i, comp_req_i, comp_id_i,
        input  claim_vld_o, claim_id_o, clam_o, comp_o, irq_o
    );
endinterface

// File: rtl/plic_target.sv
// Per-hart-context PLIC target: priority arbitration, threshold notification,
// claim FSM with a settle window, and filtered complete handling.
module plic_target #(
    parameter int SRC_NUM    = 31,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = $clog2(SRC_NUM + 1)
) (
    input logic          clk_i,
    input logic          rst_i,
    plic_target_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RSP, SETTLE} state_t;

    state_t                state;
    logic [1:0]            settle_cnt;
    logic [ID_WIDTH-1:0]   max_id_q;
    logic [PRIO_WIDTH-1:0] max_prio_q;
    logic [ID_WIDTH-1:0]   claim_id_q;
    logic [SRC_NUM-1:0]    claimed_q;

    logic [ID_WIDTH-1:0]   win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic                  comp_valid;
    logic [SRC_NUM-1:0]    comp_hit;
    logic [SRC_NUM-1:0]    claim_set;

    // Strict '>' while scanning upward keeps the lowest ID on a priority tie,
    // and a zero priority can never beat the initial zero.
    always_comb begin
        // NOTE: defaults before the loop keep this block latch-free; blocking
        // assignments are correct here because it is purely combinational.
        win_id   = '0;
        win_prio = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            if (bus.ip_i[k] && bus.ie_i[k] &&
                (bus.prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > win_prio)) begin
                win_id   = ID_WIDTH'(k + 1);
                win_prio = bus.prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

    always_comb begin
        comp_valid = bus.comp_req_i && (bus.comp_id_i != '0) &&
                     (int'(bus.comp_id_i) <= SRC_NUM);
        comp_hit   = '0;
        if (comp_valid)
            comp_hit = (SRC_NUM'(1) << (bus.comp_id_i - ID_WIDTH'(1))) &
                       bus.ie_i & claimed_q;
        claim_set  = '0;
        if (state == RSP && claim_id_q != '0)
            claim_set = SRC_NUM'(1) << (claim_id_q - ID_WIDTH'(1));
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // flop samples pre-edge values; claimed_q is real state and is reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            max_id_q        <= '0;
            max_prio_q      <= '0;
            claim_id_q      <= '0;
            claimed_q       <= '0;
            bus.irq_o       <= 1'b0;
            bus.claim_vld_o <= 1'b0;
            bus.claim_id_o  <= '0;
            bus.clam_o      <= '0;
            bus.comp_o      <= '0;
        end else begin
            max_id_q        <= win_id;
            max_prio_q      <= win_prio;
            bus.irq_o       <= (state == IDLE) && (max_prio_q > bus.thold_i);
            bus.claim_vld_o <= 1'b0;
            bus.clam_o      <= '0;
            bus.comp_o      <= comp_hit;
            // Complete is checked against pre-claim state; a same-bit set wins.
            claimed_q       <= (claimed_q & ~comp_hit) | claim_set;

            case (state)
                IDLE: begin
                    if (bus.claim_req_i) begin
                        claim_id_q <= max_id_q;
                        state      <= RSP;
                    end
                end
                RSP: begin
                    bus.claim_vld_o <= 1'b1;
                    bus.claim_id_o  <= claim_id_q;
                    bus.clam_o      <= claim_set;
                    settle_cnt      <= 2'd2;
                    state           <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 2'd1;
                    if (settle_cnt == 2'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
